dfi_phy_init_responder: RTL and testbench
=========================================

DFI_PHY_INIT_RESPONDER -- requirements
Module: dfi_phy_init_responder

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 64, cycles from accepted dfi_init_start to dfi_init_complete.
REQ-002 SHALL have parameter LVL_PERIOD, default 4096, READY cycles between leveling requests.
REQ-003 SHALL have parameter LVL_CYCLES, default 32, cycles a leveling run lasts after enable.
REQ-004 SHALL have port core_clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port core_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port dfi_init_start  in  1  controller requests PHY init.
REQ-007 SHALL have port dfi_freq_ratio  in  2  controller frequency ratio; 2'b11 is the only supported value (1:4).
REQ-008 SHALL have port dfi_dram_clk_disable  in  1  controller DRAM clock disable.
REQ-009 SHALL have port dfi_init_complete  out  1  PHY initialised.
REQ-010 SHALL have port dfi_rdlvl_req  out  1  PHY requests read leveling.
REQ-011 SHALL have port dfi_wrlvl_req  out  1  PHY requests write leveling.
REQ-012 SHALL have port dfi_rdlvl_en  in  1  controller grants or runs read leveling.
REQ-013 SHALL have port dfi_wrlvl_en  in  1  controller grants or runs write leveling.
REQ-014 SHALL have port lvl_done  out  1  one-cycle pulse when a leveling run finishes.
REQ-015 SHALL have port cfg_err  out  1  sticky; unsupported dfi_freq_ratio seen at init start.

Function
REQ-016 SHALL implement the states IDLE, INIT, READY, RD_REQ, RD_RUN, WR_REQ and WR_RUN.
REQ-017 IDLE: on dfi_init_start=1, SHALL sample dfi_freq_ratio and go to INIT; a value other than 2'b11 SHALL set cfg_err, and INIT SHALL still proceed.
REQ-018 INIT: SHALL count INIT_CYCLES cycles, then go to READY; dfi_init_complete SHALL rise on the first READY cycle, exactly INIT_CYCLES+1 cycles after the start was sampled.
REQ-019 dfi_init_start dropping in any state other than IDLE SHALL return the block to IDLE, clear dfi_init_complete and clear all requests the next cycle.
REQ-020 READY: SHALL count cycles while dfi_dram_clk_disable=0 and freeze the count while it is 1.
REQ-021 On count reaching LVL_PERIOD, SHALL go alternately to RD_REQ, then WR_REQ, starting with read after each init; the count SHALL clear on leaving READY.
REQ-022 RD_REQ/WR_REQ: SHALL hold the matching req high until the matching en is 1, then go to RD_RUN/WR_RUN and drop the req in the same cycle the state changes.
REQ-023 RD_RUN/WR_RUN: SHALL count LVL_CYCLES cycles while en=1, then pulse lvl_done for one cycle and return to READY.
REQ-024 en dropping during a RUN state SHALL abort the run with no lvl_done pulse, return to READY, and hand the next request to the other leveling type.
REQ-025 dfi_init_complete SHALL stay 1 through all leveling states.
REQ-026 rdlvl_req and wrlvl_req SHALL never both be 1.
REQ-027 An en that arrives without a pending request SHALL be ignored.
REQ-028 Every counter SHALL saturate at its terminal value and never wrap.
REQ-029 Counter widths SHALL be $clog2(parameter+1).

Reset
REQ-030 With core_rst=1 at a clock edge, the state SHALL become IDLE and all counters 0.
REQ-031 During reset, dfi_init_complete, both req outputs, lvl_done and cfg_err SHALL all be 0.
REQ-032 Reset SHALL take priority over every other input, including in the middle of a leveling run.

Configuration
REQ-033 With macro DFI_PHY_PERIODIC_LVL_EN defined, periodic leveling SHALL behave per REQ-020 to REQ-024.
REQ-034 Without DFI_PHY_PERIODIC_LVL_EN, the READY counter and leveling states SHALL be absent; dfi_rdlvl_req, dfi_wrlvl_req and lvl_done SHALL be constant 0; en inputs SHALL be ignored.

Verification
REQ-035 Reset, then init_start=1 with ratio 2'b11 -> init_complete rises exactly 65 cycles later and cfg_err stays 0.
REQ-036 init_start=1 with ratio 2'b01 -> cfg_err=1 and stays set; init_complete still asserted after 65 cycles.
REQ-037 LVL_PERIOD=16, LVL_CYCLES=4, macro defined, READY reached -> rdlvl_req rises after 16 cycles; rdlvl_en=1 -> req drops and lvl_done pulses 4 cycles later; the next request is wrlvl_req after 16 more cycles.
REQ-038 dram_clk_disable=1 for 10 cycles within the period -> the request arrives 10 cycles later than it would otherwise.
REQ-039 Drop rdlvl_en 2 cycles into RD_RUN -> no lvl_done pulse, back to READY, next request is wrlvl_req; drop init_start during WR_REQ -> everything returns to 0 the next cycle.
REQ-040 Build without the macro -> both req outputs stay 0 for 10000 cycles after init_complete.

Source files
------------

// File: rtl/dfi_phy_init_responder_if.sv
// DFI init/leveling handshake bundle between memory controller (master) and
// PHY responder (slave).
interface dfi_phy_init_responder_if;
  logic       dfi_init_start;
  logic [1:0] dfi_freq_ratio;
  logic       dfi_dram_clk_disable;
  logic       dfi_init_complete;
  logic       dfi_rdlvl_req;
  logic       dfi_wrlvl_req;
  logic       dfi_rdlvl_en;
  logic       dfi_wrlvl_en;
  logic       lvl_done;
  logic       cfg_err;

  modport master (
    output dfi_init_start, dfi_freq_ratio, dfi_dram_clk_disable,
           dfi_rdlvl_en, dfi_wrlvl_en,
    input  dfi_init_complete, dfi_rdlvl_req, dfi_wrlvl_req, lvl_done, cfg_err
  );

  modport slave (
    input  dfi_init_start, dfi_freq_ratio, dfi_dram_clk_disable,
           dfi_rdlvl_en, dfi_wrlvl_en,
    output dfi_init_complete, dfi_rdlvl_req, dfi_wrlvl_req, lvl_done, cfg_err
  );
endinterface

// File: rtl/dfi_phy_init_responder.sv
// DFI PHY init responder; periodic read/write leveling requests are built only
// when DFI_PHY_PERIODIC_LVL_EN is defined.
module dfi_phy_init_responder #(
  parameter int INIT_CYCLES = 64,
  parameter int LVL_PERIOD  = 4096,
  parameter int LVL_CYCLES  = 32
) (
  input logic                     core_clk,
  input logic                     core_rst,
  dfi_phy_init_responder_if.slave bus
);
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int PER_W  = $clog2(LVL_PERIOD + 1);
  localparam int RUN_W  = $clog2(LVL_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INIT, READY, RD_REQ, RD_RUN, WR_REQ, WR_RUN} state_t;

  state_t            state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic              cfg_err_q;

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

`ifdef DFI_PHY_PERIODIC_LVL_EN
  logic [PER_W-1:0] lvl_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             next_wr;
  logic             lvl_done_q;
  logic             done_nxt;
`endif

  always_comb begin
    state_nxt = state;
`ifdef DFI_PHY_PERIODIC_LVL_EN
    done_nxt  = 1'b0;
`endif
    case (state)
      IDLE: if (bus.dfi_init_start) state_nxt = INIT;
      INIT: begin
        if (!bus.dfi_init_start) state_nxt = IDLE;
        else if (init_cnt == INIT_W'(INIT_CYCLES)) state_nxt = READY;
      end
      READY: begin
        if (!bus.dfi_init_start) state_nxt = IDLE;
`ifdef DFI_PHY_PERIODIC_LVL_EN
        else if (!bus.dfi_dram_clk_disable && lvl_cnt == PER_W'(LVL_PERIOD - 1))
          state_nxt = next_wr ? WR_REQ : RD_REQ;
`endif
      end
`ifdef DFI_PHY_PERIODIC_LVL_EN
      RD_REQ: begin
        if (!bus.dfi_init_start) state_nxt = IDLE;
        else if (bus.dfi_rdlvl_en) state_nxt = RD_RUN;
      end
      WR_REQ: begin
        if (!bus.dfi_init_start) state_nxt = IDLE;
        else if (bus.dfi_wrlvl_en) state_nxt = WR_RUN;
      end
      // Losing the enable mid-run aborts silently; completion pulses lvl_done.
      RD_RUN: begin
        if (!bus.dfi_init_start) state_nxt = IDLE;
        else if (!bus.dfi_rdlvl_en) state_nxt = READY;
        else if (run_cnt == RUN_W'(LVL_CYCLES - 1)) begin
          state_nxt = READY;
          done_nxt  = 1'b1;
        end
      end
      WR_RUN: begin
        if (!bus.dfi_init_start) state_nxt = IDLE;
        else if (!bus.dfi_wrlvl_en) state_nxt = READY;
        else if (run_cnt == RUN_W'(LVL_CYCLES - 1)) begin
          state_nxt = READY;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state     <= IDLE;
      init_cnt  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == INIT) ? INIT_W'(sat_inc(32'(init_cnt), INIT_CYCLES)) : '0;
      if (state == IDLE && bus.dfi_init_start && bus.dfi_freq_ratio != 2'b11)
        cfg_err_q <= 1'b1;
    end
  end

`ifdef DFI_PHY_PERIODIC_LVL_EN
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      lvl_cnt    <= '0;
      run_cnt    <= '0;
      next_wr    <= 1'b0;
      lvl_done_q <= 1'b0;
    end else begin
      lvl_done_q <= done_nxt;
      // Period count freezes while the DRAM clock is stopped, clears on exit.
      if (state == READY && state_nxt == READY) begin
        if (!bus.dfi_dram_clk_disable)
          lvl_cnt <= PER_W'(sat_inc(32'(lvl_cnt), LVL_PERIOD));
      end else begin
        lvl_cnt <= '0;
      end
      run_cnt <= ((state == RD_RUN || state == WR_RUN) && state_nxt == state)
                 ? RUN_W'(sat_inc(32'(run_cnt), LVL_CYCLES)) : '0;
      if (state == INIT) next_wr <= 1'b0;
      else if (state == READY && state_nxt == RD_REQ) next_wr <= 1'b1;
      else if (state == READY && state_nxt == WR_REQ) next_wr <= 1'b0;
    end
  end

  assign bus.dfi_rdlvl_req = !core_rst && state == RD_REQ;
  assign bus.dfi_wrlvl_req = !core_rst && state == WR_REQ;
  assign bus.lvl_done      = !core_rst && lvl_done_q;
`else
  logic unused_lvl;
  assign unused_lvl = ^{bus.dfi_rdlvl_en, bus.dfi_wrlvl_en, bus.dfi_dram_clk_disable,
                        PER_W'(LVL_PERIOD), RUN_W'(LVL_CYCLES)};
  assign bus.dfi_rdlvl_req = 1'b0;
  assign bus.dfi_wrlvl_req = 1'b0;
  assign bus.lvl_done      = 1'b0;
`endif

  assign bus.dfi_init_complete = !core_rst &&
    (state == READY || state == RD_REQ || state == RD_RUN ||
     state == WR_REQ || state == WR_RUN);
  assign bus.cfg_err = !core_rst && cfg_err_q;
endmodule

// File: tb/tb_dfi_phy_init_responder.sv
// Randomized bench for dfi_phy_init_responder; leveling scenarios run when
// DFI_PHY_PERIODIC_LVL_EN is defined, otherwise the quiet-leveling scenario.
module tb_dfi_phy_init_responder;
  localparam int INIT_CYCLES = 64;
  localparam int LVL_PERIOD  = 16;
  localparam int LVL_CYCLES  = 4;
  localparam int MAX_WAIT    = 400;

  logic core_clk = 1'b0;
  logic core_rst = 1'b1;
  always #5 core_clk = ~core_clk;

  dfi_phy_init_responder_if dfi ();

  dfi_phy_init_responder #(
    .INIT_CYCLES(INIT_CYCLES),
    .LVL_PERIOD (LVL_PERIOD),
    .LVL_CYCLES (LVL_CYCLES)
  ) dut (
    .core_clk(core_clk),
    .core_rst(core_rst),
    .bus     (dfi.slave)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  logic err_model = 1'b0;
  logic next_wr   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge core_clk);
    @(negedge core_clk);
  endtask

  function automatic logic [4:0] outs();
    return {dfi.dfi_init_complete, dfi.dfi_rdlvl_req, dfi.dfi_wrlvl_req,
            dfi.lvl_done, dfi.cfg_err};
  endfunction

  task automatic quiet_inputs();
    dfi.dfi_dram_clk_disable = 1'b0;
    dfi.dfi_rdlvl_en         = 1'b0;
    dfi.dfi_wrlvl_en         = 1'b0;
  endtask

  // Init completes INIT_CYCLES+1 cycles after the sampling edge.
  task automatic do_init(input logic [1:0] ratio);
    int n;
    repeat ($urandom_range(0, 4)) tick();
    dfi.dfi_freq_ratio = ratio;
    dfi.dfi_init_start = 1'b1;
    if (ratio != 2'b11) err_model = 1'b1;
    next_wr = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        check("cfg_err_at_start", dfi.cfg_err, err_model);
        dfi.dfi_freq_ratio = 2'($urandom);
      end
    end while (!dfi.dfi_init_complete && n < MAX_WAIT);
    check("init_latency", n - 1, INIT_CYCLES + 1);
  endtask

  task automatic drop_start();
    dfi.dfi_init_start = 1'b0;
    quiet_inputs();
    tick();
    check("drop_start", outs(), {4'b0000, err_model});
  endtask

`ifdef DFI_PHY_PERIODIC_LVL_EN
  // A request appears right after the LVL_PERIOD-th READY cycle with the DRAM clock running.
  task automatic ready_period(input bit burst10);
    int   enabled, ticks, off, burst_left;
    bit   stray;
    logic exp_wr;
    enabled    = 0;
    ticks      = 0;
    stray      = 1'b0;
    exp_wr     = next_wr;
    off        = $urandom_range(0, LVL_PERIOD - 2);
    burst_left = burst10 ? 10 : 0;
    while (enabled < LVL_PERIOD && ticks < MAX_WAIT) begin
      if (burst10) dfi.dfi_dram_clk_disable = (enabled == off && burst_left > 0);
      else         dfi.dfi_dram_clk_disable = ($urandom_range(0, 3) == 0);
      dfi.dfi_rdlvl_en = 1'($urandom);
      dfi.dfi_wrlvl_en = 1'($urandom);
      tick();
      ticks++;
      if (!dfi.dfi_dram_clk_disable) enabled++;
      else if (burst_left > 0) burst_left--;
      if (enabled < LVL_PERIOD &&
          (dfi.dfi_rdlvl_req || dfi.dfi_wrlvl_req || dfi.lvl_done || !dfi.dfi_init_complete))
        stray = 1'b1;
    end
    check("ready_quiet", stray, 1'b0);
    if (burst10) check("burst_delay", ticks, LVL_PERIOD + 10);
    check("req_type", {dfi.dfi_rdlvl_req, dfi.dfi_wrlvl_req}, exp_wr ? 2'b01 : 2'b10);
    next_wr = ~next_wr;
    quiet_inputs();
  endtask

  // abort_at in 1..LVL_CYCLES drops the enable on that run cycle; 0 completes.
  task automatic lvl_run(input int abort_at);
    int   wait_g;
    logic is_wr;
    wait_g = $urandom_range(0, 3);
    is_wr  = dfi.dfi_wrlvl_req;
    for (int i = 0; i < wait_g; i++) begin
      if (is_wr) dfi.dfi_rdlvl_en = 1'($urandom);
      else       dfi.dfi_wrlvl_en = 1'($urandom);
      tick();
    end
    check("req_held", {dfi.dfi_init_complete, dfi.dfi_rdlvl_req, dfi.dfi_wrlvl_req},
          is_wr ? 3'b101 : 3'b110);
    dfi.dfi_rdlvl_en = !is_wr;
    dfi.dfi_wrlvl_en = is_wr;
    tick();
    check("grant", outs(), {4'b1000, err_model});
    for (int k = 1; k <= LVL_CYCLES; k++) begin
      if (k == abort_at) quiet_inputs();
      tick();
      if (k == abort_at) begin
        check("abort", outs(), {4'b1000, err_model});
        break;
      end
      if (k == LVL_CYCLES) check("lvl_done", dfi.lvl_done, 1'b1);
      else if (dfi.lvl_done) check("lvl_done_early", dfi.lvl_done, 1'b0);
    end
    quiet_inputs();
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r;
    // Reset dominates a live start request with a bad ratio.
    dfi.dfi_init_start = 1'b1;
    dfi.dfi_freq_ratio = 2'b01;
    dfi.dfi_dram_clk_disable = 1'b0;
    dfi.dfi_rdlvl_en = 1'b1;
    dfi.dfi_wrlvl_en = 1'b1;
    repeat (3) tick();
    check("reset_outs", outs(), 5'b00000);
    dfi.dfi_init_start = 1'b0;
    quiet_inputs();
    core_rst = 1'b0;
    tick();
    check("idle_outs", outs(), 5'b00000);

    do_init(2'b01);
    drop_start();
    do_init(2'b11);
    check("cfg_err_sticky", dfi.cfg_err, 1'b1);
    drop_start();
    core_rst = 1'b1;
    tick();
    check("reset_clears_err", outs(), 5'b00000);
    err_model = 1'b0;
    core_rst  = 1'b0;
    do_init(2'b11);
    check("cfg_err_clean", dfi.cfg_err, 1'b0);

`ifdef DFI_PHY_PERIODIC_LVL_EN
    ready_period(1'b0); lvl_run(0);
    ready_period(1'b1); lvl_run(0);
    ready_period(1'b0); lvl_run(2);
    ready_period(1'b0);
    check("wr_after_abort", dfi.dfi_wrlvl_req, 1'b1);
    drop_start();
    do_init(2'b11);
    ready_period(1'b0);
    check("rd_first_after_init", dfi.dfi_rdlvl_req, 1'b1);
    lvl_run(0);
    repeat (6) begin
      ready_period(1'($urandom_range(0, 1)));
      lvl_run($urandom_range(0, LVL_CYCLES));
    end
    // Reset in the middle of a run.
    ready_period(1'b0);
    dfi.dfi_rdlvl_en = dfi.dfi_rdlvl_req;
    dfi.dfi_wrlvl_en = dfi.dfi_wrlvl_req;
    repeat (2) tick();
    core_rst = 1'b1;
    dfi.dfi_init_start = 1'b0;
    tick();
    check("reset_mid_run", outs(), 5'b00000);
    err_model = 1'b0;
    core_rst  = 1'b0;
    quiet_inputs();
    do_init(2'b11);
`else
    begin
      bit noisy;
      noisy = 1'b0;
      for (int i = 0; i < 10000; i++) begin
        dfi.dfi_rdlvl_en = 1'($urandom);
        dfi.dfi_wrlvl_en = 1'($urandom);
        dfi.dfi_dram_clk_disable = 1'($urandom);
        tick();
        if (dfi.dfi_rdlvl_req || dfi.dfi_wrlvl_req || dfi.lvl_done || !dfi.dfi_init_complete)
          noisy = 1'b1;
      end
      check("no_lvl_10000", noisy, 1'b0);
      quiet_inputs();
    end
`endif

    repeat (3) begin
      drop_start();
      r = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom);
      do_init(r);
    end
    core_rst = 1'b1;
    tick();
    check("final_reset", outs(), 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
